// File: rtl/mel_seq_pkg.sv
// Shared types and sizing defaults for the mel filterbank MAC sequencer.
package mel_seq_pkg;

  localparam int POWER_W_DEF  = 31;
  localparam int COEFF_W_DEF  = 16;
  localparam int NUM_BINS_DEF = 257;
  localparam int NUM_MELS_DEF = 40;
  localparam int MEL_W_DEF    = 6;

  // The widest triangle spans fewer than 128 bins: 7 guard bits.
  localparam int BAND_GUARD_W = 7;

  function automatic int accum_w(input int power_w, input int coeff_w);
    return power_w + coeff_w + BAND_GUARD_W;
  endfunction

  localparam int ACCUM_W_DEF = accum_w(POWER_W_DEF, COEFF_W_DEF);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EMIT,
    S_MAC,
    S_FLUSH,
    S_FINAL
  } mel_seq_state_e;

  typedef struct packed {
    logic                   en;
    logic [MEL_W_DEF-1:0]   band_lo;
    logic [COEFF_W_DEF-1:0] w_lo;
    logic [COEFF_W_DEF-1:0] w_hi;
  } mel_coef_t;

endpackage

// File: rtl/mel_mac_sequencer_emit_reg.sv
// Valid/ready holding register for completed mel band results.
module mel_emit_reg #(
  parameter int DATA_W = 54,
  parameter int IDX_W  = 6
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic              last_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [IDX_W-1:0]  idx_o,
  output logic              last_o,
  output logic              fire_o
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              last_q, last_d;

  assign fire_o = valid_q & ready_i;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    idx_d   = idx_q;
    last_d  = last_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      idx_d   = idx_i;
      last_d  = last_i;
    end else if (fire_o) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign idx_o   = idx_q;
  assign last_o  = last_q;

endmodule

// File: rtl/mel_mac_sequencer.sv
// Sequences two MAC lanes into triangular mel band energies.
// Define MEL_SEQ_FRAME_CNT_EN to add frame_done_o / frame_count_o.
module mel_mac_sequencer
  import mel_seq_pkg::*;
#(
  parameter int POWER_W  = POWER_W_DEF,
  parameter int COEFF_W  = COEFF_W_DEF,
  parameter int ACCUM_W  = accum_w(POWER_W, COEFF_W),
  parameter int NUM_BINS = NUM_BINS_DEF,
  parameter int NUM_MELS = NUM_MELS_DEF,
  parameter int MEL_W    = MEL_W_DEF
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        power_valid_i,
  output logic                        power_ready_o,
  input  logic [POWER_W-1:0]          power_i,
  output logic [$clog2(NUM_BINS)-1:0] coef_addr_o,
  input  logic [MEL_W+2*COEFF_W:0]    coef_data_i,
  output logic [POWER_W-1:0]          mac_power_o,
  output logic [2*COEFF_W-1:0]        mac_weight_o,
  output logic [1:0]                  mac_accumulate_o,
  output logic [1:0]                  mac_clear_o,
  input  logic [2*ACCUM_W-1:0]        mac_accum_i,
  output logic                        mel_valid_o,
  input  logic                        mel_ready_i,
  output logic [ACCUM_W-1:0]          mel_data_o,
  output logic [MEL_W-1:0]            mel_idx_o,
  output logic                        mel_last_o
`ifdef MEL_SEQ_FRAME_CNT_EN
  ,
  output logic                        frame_done_o,
  output logic [15:0]                 frame_count_o
`endif
);

  localparam int BIN_W = $clog2(NUM_BINS);

  mel_seq_state_e       state_q, state_d;
  logic [BIN_W-1:0]     bin_q, bin_d;
  logic [MEL_W-1:0]     prev_lo_q, prev_lo_d;
  logic [MEL_W-1:0]     lo_q, lo_d;
  logic                 en_q, en_d;
  logic [POWER_W-1:0]   power_q, power_d;
  logic [2*COEFF_W-1:0] weight_q, weight_d;
  logic [1:0]           lane_en_q, lane_en_d;

  logic               c_en, hi_ok;
  logic [MEL_W-1:0]   c_lo;
  logic [COEFF_W-1:0] c_wlo, c_whi;
  logic [1:0]         lo_mask, clear;
  logic               emit_load, emit_last, emit_fire;
  logic [ACCUM_W-1:0] emit_data;

  assign c_en  = coef_data_i[MEL_W+2*COEFF_W];
  assign c_lo  = coef_data_i[2*COEFF_W +: MEL_W];
  assign c_wlo = coef_data_i[COEFF_W +: COEFF_W];
  assign c_whi = coef_data_i[0 +: COEFF_W];

  // w_hi feeds band_lo+1, which may not exist for the top band.
  assign hi_ok   = (int'(c_lo) + 1) < NUM_MELS;
  assign lo_mask = c_lo[0] ? 2'b10 : 2'b01;

  assign emit_data = prev_lo_q[0] ? mac_accum_i[ACCUM_W +: ACCUM_W]
                                  : mac_accum_i[0 +: ACCUM_W];
  assign emit_last = (state_q == S_FLUSH);

  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    prev_lo_d = prev_lo_q;
    lo_d      = lo_q;
    en_d      = en_q;
    power_d   = power_q;
    weight_d  = weight_q;
    lane_en_d = lane_en_q;
    emit_load = 1'b0;
    clear     = 2'b00;
    unique case (state_q)
      S_IDLE: begin
        if (power_valid_i) begin
          power_d = power_i;
          if (bin_q == '0) clear = 2'b11;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        en_d      = c_en;
        lo_d      = c_lo;
        weight_d  = c_lo[0] ? {c_wlo, c_whi} : {c_whi, c_wlo};
        lane_en_d = c_en ? (lo_mask | (hi_ok ? ~lo_mask : 2'b00)) : 2'b00;
        if (c_en && bin_q != '0 && c_lo == prev_lo_q + 1'b1) begin
          emit_load = 1'b1;
          state_d   = S_EMIT;
        end else begin
          state_d = S_MAC;
        end
      end
      S_EMIT: begin
        if (emit_fire) begin
          clear   = prev_lo_q[0] ? 2'b10 : 2'b01;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        if (en_q) prev_lo_d = lo_q;
        if (bin_q == BIN_W'(NUM_BINS - 1)) begin
          state_d = S_FLUSH;
        end else begin
          bin_d   = bin_q + 1'b1;
          state_d = S_IDLE;
        end
      end
      S_FLUSH: begin
        emit_load = 1'b1;
        state_d   = S_FINAL;
      end
      S_FINAL: begin
        if (emit_fire) begin
          clear     = 2'b11;
          bin_d     = '0;
          prev_lo_d = '0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      bin_q     <= '0;
      prev_lo_q <= '0;
      lo_q      <= '0;
      en_q      <= 1'b0;
      power_q   <= '0;
      weight_q  <= '0;
      lane_en_q <= 2'b00;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      prev_lo_q <= prev_lo_d;
      lo_q      <= lo_d;
      en_q      <= en_d;
      power_q   <= power_d;
      weight_q  <= weight_d;
      lane_en_q <= lane_en_d;
    end
  end

  mel_emit_reg #(
    .DATA_W(ACCUM_W),
    .IDX_W (MEL_W)
  ) u_emit (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .load_i (emit_load),
    .data_i (emit_data),
    .idx_i  (prev_lo_q),
    .last_i (emit_last),
    .ready_i(mel_ready_i),
    .valid_o(mel_valid_o),
    .data_o (mel_data_o),
    .idx_o  (mel_idx_o),
    .last_o (mel_last_o),
    .fire_o (emit_fire)
  );

  assign power_ready_o    = (state_q == S_IDLE);
  assign coef_addr_o      = bin_q;
  assign mac_power_o      = power_q;
  assign mac_weight_o     = weight_q;
  assign mac_accumulate_o = (state_q == S_MAC) ? lane_en_q : 2'b00;
  assign mac_clear_o      = clear;

`ifdef MEL_SEQ_FRAME_CNT_EN
  logic        done_q, done_d;
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    done_d = (state_q == S_FINAL) && emit_fire;
    cnt_d  = cnt_q + (done_d ? 16'd1 : 16'd0);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      done_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      done_q <= done_d;
      cnt_q  <= cnt_d;
    end
  end

  assign frame_done_o  = done_q;
  assign frame_count_o = cnt_q;
`endif

endmodule
